// File: rtl/crc_frame_serializer.sv
// -----------------------------------------------------------------------------
// crc_frame_serializer
// Byte-to-serial framer that feeds a serial CRC-8 generator. Frame words are
// accepted over a valid/ready handshake and shifted out LSB first on Data while
// Active is high. After the last bit, Active is held low for CRC_W cycles so the
// generator can shift its CRC out, then Crc_Clr pulses for one cycle so the
// generator's LFSR is reseeded before the next frame.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module crc_frame_serializer #(
    parameter int DATA_W = 8,
    parameter int CRC_W  = 8,
    parameter int LEN_W  = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [DATA_W-1:0] In_Data,
    input  logic              In_Valid,
    input  logic              In_Last,
    output logic              In_Ready,
    output logic              Data,
    output logic              Active,
    output logic              Busy,
    output logic              Frame_Done,
    output logic [LEN_W-1:0]  Frame_Len,
    output logic              Underrun,
    output logic              Crc_Clr
);

    // Counter widths; a width of at least one bit keeps degenerate parameters legal.
    localparam int BIT_CW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int TAIL_CW = (CRC_W  > 1) ? $clog2(CRC_W)  : 1;

    localparam logic [BIT_CW-1:0]  BIT_LAST  = BIT_CW'(DATA_W - 1);
    localparam logic [TAIL_CW-1:0] TAIL_LAST = TAIL_CW'(CRC_W - 1);
    localparam logic [BIT_CW-1:0]  BIT_ZERO  = {BIT_CW{1'b0}};
    localparam logic [TAIL_CW-1:0] TAIL_ZERO = {TAIL_CW{1'b0}};
    localparam logic [LEN_W-1:0]   LEN_ONE   = LEN_W'(1);
    localparam logic [LEN_W-1:0]   LEN_MAX   = {LEN_W{1'b1}};

    // FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_TAIL  = 2'd2;
    localparam logic [1:0] ST_CLR   = 2'd3;

    // Word counter increment that sticks at its maximum value.
    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] value);
        logic [LEN_W-1:0] result;
        if (value == LEN_MAX) begin
            result = value;
        end else begin
            result = value + LEN_ONE;
        end
        return result;
    endfunction

    // Registered state
    logic [1:0]         state_r;
    logic [DATA_W-1:0]  shift_r;
    logic               last_r;
    logic [BIT_CW-1:0]  bit_cnt_r;
    logic [TAIL_CW-1:0] tail_cnt_r;
    logic [LEN_W-1:0]   word_cnt_r;
    logic               data_r;
    logic               active_r;
    logic [LEN_W-1:0]   frame_len_r;
    logic               frame_done_r;
    logic               underrun_r;
    logic               crc_clr_r;

    // Next-state values
    logic [1:0]         state_s;
    logic [DATA_W-1:0]  shift_s;
    logic               last_s;
    logic [BIT_CW-1:0]  bit_cnt_s;
    logic [TAIL_CW-1:0] tail_cnt_s;
    logic [LEN_W-1:0]   word_cnt_s;
    logic               data_s;
    logic               active_s;
    logic [LEN_W-1:0]   frame_len_s;
    logic               frame_done_s;
    logic               underrun_s;
    logic               crc_clr_s;

    // Handshake decode
    logic               in_ready_s;
    logic               busy_s;
    logic               take_s;

    // Ready/busy decode from the current state; ready in SHIFT only on the final
    // bit of a word that is not flagged last, so the next word follows gaplessly.
    always_comb begin
        in_ready_s = 1'b0;
        busy_s     = 1'b1;
        case (state_r)
            ST_IDLE: begin
                in_ready_s = 1'b1;
                busy_s     = 1'b0;
            end
            ST_SHIFT: begin
                busy_s = 1'b1;
                if ((bit_cnt_r == BIT_LAST) && !last_r) begin
                    in_ready_s = 1'b1;
                end else begin
                    in_ready_s = 1'b0;
                end
            end
            ST_TAIL: begin
                in_ready_s = 1'b0;
                busy_s     = 1'b1;
            end
            ST_CLR: begin
                in_ready_s = 1'b0;
                busy_s     = 1'b1;
            end
            default: begin
                in_ready_s = 1'b0;
                busy_s     = 1'b1;
            end
        endcase
        take_s = In_Valid & in_ready_s;
    end

    // Next-state and datapath logic for the framing FSM.
    always_comb begin
        state_s      = state_r;
        shift_s      = shift_r;
        last_s       = last_r;
        bit_cnt_s    = bit_cnt_r;
        tail_cnt_s   = tail_cnt_r;
        word_cnt_s   = word_cnt_r;
        data_s       = data_r;
        active_s     = active_r;
        frame_len_s  = frame_len_r;
        frame_done_s = 1'b0;
        underrun_s   = 1'b0;
        crc_clr_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (take_s) begin
                    // bit 0 goes straight to the output register; the rest queue up
                    shift_s    = In_Data >> 1;
                    last_s     = In_Last;
                    data_s     = In_Data[0];
                    active_s   = 1'b1;
                    bit_cnt_s  = BIT_ZERO;
                    word_cnt_s = LEN_ONE;
                    state_s    = ST_SHIFT;
                end else begin
                    data_s   = 1'b0;
                    active_s = 1'b0;
                end
            end

            ST_SHIFT: begin
                if (bit_cnt_r != BIT_LAST) begin
                    data_s    = shift_r[0];
                    shift_s   = shift_r >> 1;
                    bit_cnt_s = bit_cnt_r + BIT_CW'(1);
                end else if (take_s) begin
                    // back-to-back word: Active stays high across the boundary
                    shift_s    = In_Data >> 1;
                    last_s     = In_Last;
                    data_s     = In_Data[0];
                    active_s   = 1'b1;
                    bit_cnt_s  = BIT_ZERO;
                    word_cnt_s = sat_inc(word_cnt_r);
                    state_s    = ST_SHIFT;
                end else begin
                    // either a clean end of frame or a missing word; in both cases
                    // the CRC tail covers what has been sent so far
                    underrun_s = ~last_r;
                    data_s     = 1'b0;
                    active_s   = 1'b0;
                    tail_cnt_s = TAIL_ZERO;
                    state_s    = ST_TAIL;
                end
            end

            ST_TAIL: begin
                data_s   = 1'b0;
                active_s = 1'b0;
                if (tail_cnt_r == TAIL_LAST) begin
                    frame_done_s = 1'b1;
                    crc_clr_s    = 1'b1;
                    frame_len_s  = word_cnt_r;
                    state_s      = ST_CLR;
                end else begin
                    tail_cnt_s = tail_cnt_r + TAIL_CW'(1);
                end
            end

            ST_CLR: begin
                data_s   = 1'b0;
                active_s = 1'b0;
                state_s  = ST_IDLE;
            end

            default: begin
                data_s   = 1'b0;
                active_s = 1'b0;
                state_s  = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset; a mid-frame reset
    // abandons the frame without a tail or completion pulse.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r      <= ST_IDLE;
            shift_r      <= {DATA_W{1'b0}};
            last_r       <= 1'b0;
            bit_cnt_r    <= BIT_ZERO;
            tail_cnt_r   <= TAIL_ZERO;
            word_cnt_r   <= {LEN_W{1'b0}};
            data_r       <= 1'b0;
            active_r     <= 1'b0;
            frame_len_r  <= {LEN_W{1'b0}};
            frame_done_r <= 1'b0;
            underrun_r   <= 1'b0;
            crc_clr_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            shift_r      <= shift_s;
            last_r       <= last_s;
            bit_cnt_r    <= bit_cnt_s;
            tail_cnt_r   <= tail_cnt_s;
            word_cnt_r   <= word_cnt_s;
            data_r       <= data_s;
            active_r     <= active_s;
            frame_len_r  <= frame_len_s;
            frame_done_r <= frame_done_s;
            underrun_r   <= underrun_s;
            crc_clr_r    <= crc_clr_s;
        end
    end

    assign In_Ready   = in_ready_s;
    assign Busy       = busy_s;
    assign Data       = data_r;
    assign Active     = active_r;
    assign Frame_Done = frame_done_r;
    assign Frame_Len  = frame_len_r;
    assign Underrun   = underrun_r;
    assign Crc_Clr    = crc_clr_r;

endmodule

// File: tb/tb_crc_frame_serializer.sv
// -----------------------------------------------------------------------------
// tb_crc_frame_serializer
// Scoreboard bench: the driver pushes the expected frame (bytes, length,
// underrun flag, reference CRC-8) when it issues a frame; a negedge monitor
// rebuilds bytes from the serial stream, runs a serial CRC-8 generator on
// Data/Active (reseeded by Crc_Clr and Rst) and compares on Frame_Done.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_crc_frame_serializer;

    localparam int CRC_W = 8;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic [7:0] In_Data = 8'h00;
    logic       In_Valid = 1'b0;
    logic       In_Last = 1'b0;
    logic       In_Ready;
    logic       Data;
    logic       Active;
    logic       Busy;
    logic       Frame_Done;
    logic [7:0] Frame_Len;
    logic       Underrun;
    logic       Crc_Clr;

    crc_frame_serializer #(.DATA_W(8), .CRC_W(CRC_W), .LEN_W(8)) dut (
        .Clk(Clk), .Rst(Rst), .In_Data(In_Data), .In_Valid(In_Valid),
        .In_Last(In_Last), .In_Ready(In_Ready), .Data(Data), .Active(Active),
        .Busy(Busy), .Frame_Done(Frame_Done), .Frame_Len(Frame_Len),
        .Underrun(Underrun), .Crc_Clr(Crc_Clr)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    // scoreboard
    logic [7:0] exp_bytes[$];
    int         exp_cnt[$];
    logic [7:0] exp_len[$];
    int         exp_ur[$];
    logic [7:0] exp_crc[$];
    logic [7:0] fw[$];

    // CRC-8 poly 0x07, MSB-first register, data fed LSB of each byte first
    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    function automatic logic [7:0] crc_of_frame();
        logic [7:0] c;
        logic [7:0] w;
        c = 8'h00;
        for (int i = 0; i < fw.size(); i++) begin
            w = fw[i];
            for (int j = 0; j < 8; j++) c = crc_step(c, w[j]);
        end
        return c;
    endfunction

    // monitor state
    logic       mon_bits[$];
    int         tail_n = 0;
    int         ur_cnt = 0;
    bit         in_frame = 1'b0;
    logic [7:0] gen_crc = 8'h00;
    logic [7:0] last_len = 8'h00;

    // Monitor: samples on the falling edge, checks every cycle and scores frames.
    always @(negedge Clk) begin : mon
        int n;
        bit have;
        logic [7:0] b;
        logic [7:0] el;
        if (Rst) begin
            mon_bits.delete();
            tail_n = 0; ur_cnt = 0; in_frame = 1'b0;
            gen_crc = 8'h00; last_len = 8'h00;
        end else begin
            chk("crc_clr_with_done", Crc_Clr, Frame_Done);
            if (Frame_Done) begin
                chk("done_active", Active, 0);
                chk("done_busy", Busy, 1);
                chk("done_ready", In_Ready, 0);
                chk("tail_len", tail_n, CRC_W);
                have = (exp_cnt.size() != 0);
                chk("done_expected", have, 1);
                if (have) begin
                    n  = exp_cnt.pop_front();
                    el = exp_len.pop_front();
                    chk("frame_len", Frame_Len, el);
                    chk("underrun_cnt", ur_cnt, exp_ur.pop_front());
                    chk("bit_count", mon_bits.size(), 8 * n);
                    for (int i = 0; i < n; i++) begin
                        b = 8'h00;
                        for (int j = 0; j < 8; j++)
                            if (8 * i + j < mon_bits.size()) b[j] = mon_bits[8 * i + j];
                        chk("byte", b, exp_bytes.pop_front());
                    end
                    chk("crc", gen_crc, exp_crc.pop_front());
                    last_len = el;
                end
                mon_bits.delete();
                tail_n = 0; ur_cnt = 0; in_frame = 1'b0;
            end else begin
                chk("len_hold", Frame_Len, last_len);
                if (Active) begin
                    chk("active_contig", tail_n, 0);
                    chk("busy_active", Busy, 1);
                    chk("underrun_while_active", Underrun, 0);
                    in_frame = 1'b1;
                    mon_bits.push_back(Data);
                    gen_crc = crc_step(gen_crc, Data);
                    if (In_Ready) chk("ready_pos", mon_bits.size() % 8, 0);
                end else if (in_frame) begin
                    tail_n++;
                    chk("tail_data", Data, 0);
                    chk("tail_busy", Busy, 1);
                    chk("tail_ready", In_Ready, 0);
                    if (Underrun) begin
                        ur_cnt++;
                        chk("underrun_pos", tail_n, 1);
                    end
                end else begin
                    chk("idle_busy", Busy, 0);
                    chk("idle_ready", In_Ready, 1);
                    chk("idle_data", Data, 0);
                    chk("idle_underrun", Underrun, 0);
                end
            end
            if (Crc_Clr) gen_crc = 8'h00;
        end
    end

    task automatic finish_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic send_word(input logic [7:0] d, input logic last);
        bit accepted;
        accepted = 1'b0;
        In_Valid = 1'b1;
        In_Data  = d;
        In_Last  = last;
        for (int t = 0; t < 200 && !accepted; t++) begin
            @(negedge Clk);
            accepted = In_Ready;
            @(posedge Clk);
            #1;
        end
        if (!accepted) begin
            chk("handshake_timeout", accepted, 1);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $fatal(1, "handshake bound expired");
        end
    endtask

    task automatic run_frame(input bit ur, input int junk);
        foreach (fw[i]) exp_bytes.push_back(fw[i]);
        exp_cnt.push_back(fw.size());
        exp_len.push_back((fw.size() > 255) ? 8'hFF : 8'(fw.size()));
        exp_ur.push_back(ur ? 1 : 0);
        exp_crc.push_back(crc_of_frame());
        for (int i = 0; i < fw.size(); i++)
            send_word(fw[i], !ur && (i == fw.size() - 1));
        if (ur) begin
            In_Valid = 1'b0;
            In_Last  = 1'b0;
            repeat (12) begin @(posedge Clk); #1; end
        end else begin
            // junk on the bus while the frame drains must never be taken
            for (int j = 0; j < junk; j++) begin
                In_Valid = 1'b1;
                In_Data  = 8'($urandom);
                In_Last  = 1'($urandom);
                @(posedge Clk);
                #1;
            end
            In_Valid = 1'b0;
            In_Last  = 1'b0;
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge Clk); #1; end
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog time limit reached t=%0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int n;
        int k;
        bit ur;
        Rst = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        Rst = 1'b0;
        chk("rst_data", Data, 0);
        chk("rst_active", Active, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Frame_Done, 0);
        chk("rst_underrun", Underrun, 0);
        chk("rst_crc_clr", Crc_Clr, 0);
        chk("rst_len", Frame_Len, 0);
        chk("rst_ready", In_Ready, 1);
        idle_cycles(2);

        // single word 0xA5, last
        fw.delete(); fw.push_back(8'hA5);
        run_frame(1'b0, 0);
        idle_cycles(3);

        // three words back-to-back with junk following
        fw.delete(); fw.push_back(8'h01); fw.push_back(8'h80); fw.push_back(8'hFF);
        run_frame(1'b0, 10);
        idle_cycles(2);

        // two-word frame whose second word never arrives
        fw.delete(); fw.push_back(8'h5A);
        run_frame(1'b1, 0);
        idle_cycles(10);

        // reset during bit 4 of the first word
        send_word(8'h3C, 1'b1);
        In_Valid = 1'b0;
        In_Last  = 1'b0;
        idle_cycles(4);
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        chk("abort_active", Active, 0);
        chk("abort_busy", Busy, 0);
        chk("abort_ready", In_Ready, 1);
        chk("abort_done", Frame_Done, 0);
        chk("abort_crc_clr", Crc_Clr, 0);
        chk("abort_data", Data, 0);
        idle_cycles(25);

        fw.delete(); fw.push_back(8'hA5);
        run_frame(1'b0, 0);
        idle_cycles(1);

        // long frame: word count saturates at 255
        fw.delete();
        for (int i = 0; i < 260; i++) fw.push_back(8'($urandom));
        run_frame(1'b0, 12);

        // random frames
        for (int f = 0; f < 40; f++) begin
            n  = $urandom_range(1, 20);
            ur = (n >= 2) && ($urandom_range(0, 4) == 0);
            k  = ur ? $urandom_range(1, n - 1) : n;
            fw.delete();
            for (int i = 0; i < k; i++) fw.push_back(8'($urandom));
            run_frame(ur, ur ? 0 : $urandom_range(0, 12));
            idle_cycles($urandom_range(0, 4));
        end

        for (int t = 0; t < 200 && exp_cnt.size() != 0; t++) @(posedge Clk);
        #1;
        chk("drain_empty", exp_cnt.size(), 0);
        idle_cycles(3);
        finish_run();
    end

endmodule
